// File: rtl/multicycle_decoder.sv
// Multicycle ARM-style control decoder: a registered FSM steps each
// instruction through fetch, decode and its execute/memory/writeback
// states, driving datapath selects and write enables per state.
module multicycle_decoder #(
    parameter int ALUC_W = 2,
    parameter int PC_IDX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        op,
    input  logic [5:0]        funct,
    input  logic [3:0]        rd,
    input  logic              mem_ready,
    output logic              pc_s,
    output logic              next_pc,
    output logic              reg_w,
    output logic              mem_w,
    output logic              ir_write,
    output logic              adr_src,
    output logic              alu_src_a,
    output logic [1:0]        result_src,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        imm_src,
    output logic [1:0]        reg_src,
    output logic [1:0]        flag_w,
    output logic [ALUC_W-1:0] alu_control,
    output logic              instr_done,
    output logic              illegal
);

    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] EXEC_R = 4'd6;
    localparam logic [3:0] EXEC_I = 4'd7;
    localparam logic [3:0] ALUWB  = 4'd8;
    localparam logic [3:0] BRANCH = 4'd9;

    // EOR/MOV/CMP/TST only exist with the wider ALU control
    localparam logic EXT = (ALUC_W >= 3);

    logic [3:0]        state, state_nx;
    logic [3:0]        cmd;
    logic              s_bit;
    logic              cmd_ok, cmd_arith, cmd_cmp;
    logic [ALUC_W-1:0] cmd_aluc;
    logic              decode_bad;
    logic              pc_dst;

    assign cmd    = funct[4:1];
    assign s_bit  = funct[0];
    assign pc_dst = (rd == PC_IDX[3:0]);

    // Data-processing command lookup: support, ALU code, flag class
    always_comb begin
        cmd_ok    = 1'b0;
        cmd_arith = 1'b0;
        cmd_cmp   = 1'b0;
        cmd_aluc  = '0;
        case (cmd)
            4'b0100: begin cmd_ok = 1'b1; cmd_arith = 1'b1; cmd_aluc = ALUC_W'(0); end
            4'b0010: begin cmd_ok = 1'b1; cmd_arith = 1'b1; cmd_aluc = ALUC_W'(1); end
            4'b0000: begin cmd_ok = 1'b1; cmd_aluc = ALUC_W'(2); end
            4'b1100: begin cmd_ok = 1'b1; cmd_aluc = ALUC_W'(3); end
            4'b0001: begin cmd_ok = EXT; cmd_aluc = ALUC_W'(4); end
            4'b1101: begin cmd_ok = EXT; cmd_aluc = ALUC_W'(5); end
            4'b1010: begin cmd_ok = EXT; cmd_arith = EXT; cmd_cmp = EXT; cmd_aluc = ALUC_W'(1); end
            4'b1000: begin cmd_ok = EXT; cmd_cmp = EXT; cmd_aluc = ALUC_W'(2); end
            default: ;
        endcase
    end

    assign decode_bad = (op == 2'b11) || ((op == 2'b00) && !cmd_ok);

    // Next-state selection
    always_comb begin
        state_nx = state;
        case (state)
            FETCH:  if (mem_ready) state_nx = DECODE;
            DECODE: begin
                if (decode_bad)        state_nx = FETCH;
                else if (op == 2'b01)  state_nx = MEMADR;
                else if (op == 2'b10)  state_nx = BRANCH;
                else                   state_nx = funct[5] ? EXEC_I : EXEC_R;
            end
            MEMADR: state_nx = funct[0] ? MEMRD : MEMWR;
            MEMRD:  if (mem_ready) state_nx = MEMWB;
            MEMWR:  if (mem_ready) state_nx = FETCH;
            EXEC_R, EXEC_I: state_nx = cmd_cmp ? FETCH : ALUWB;
            default: state_nx = FETCH;
        endcase
    end

    // State register; reset lands in FETCH immediately, aborting any access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_nx;
    end

    // Undecodable instruction flag, visible the cycle after DECODE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) illegal <= 1'b0;
        else     illegal <= (state == DECODE) && decode_bad;
    end

    // Per-state datapath controls; everything not named stays low
    always_comb begin
        pc_s        = 1'b0;
        next_pc     = 1'b0;
        reg_w       = 1'b0;
        mem_w       = 1'b0;
        ir_write    = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 1'b0;
        result_src  = 2'b00;
        alu_src_b   = 2'b00;
        flag_w      = 2'b00;
        alu_control = '0;
        instr_done  = 1'b0;
        imm_src     = op;
        reg_src     = {op == 2'b01, op == 2'b10};
        case (state)
            FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                next_pc    = mem_ready;
            end
            DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            MEMADR: alu_src_b = 2'b01;
            MEMRD:  adr_src = 1'b1;
            MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
                pc_s       = pc_dst;
                instr_done = 1'b1;
            end
            MEMWR: begin
                adr_src    = 1'b1;
                mem_w      = mem_ready;
                instr_done = mem_ready;
            end
            EXEC_R, EXEC_I: begin
                alu_src_b   = (state == EXEC_I) ? 2'b01 : 2'b00;
                alu_control = cmd_aluc;
                if (s_bit || cmd_cmp) flag_w = cmd_arith ? 2'b11 : 2'b10;
                instr_done  = cmd_cmp;
            end
            ALUWB: begin
                reg_w      = 1'b1;
                pc_s       = pc_dst;
                instr_done = 1'b1;
            end
            BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_s       = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_decoder.sv
// Bench for multicycle_decoder: two instances (ALUC_W=2 and 3) driven one
// instruction at a time; the expected per-cycle trace is built from the
// instruction class, then outputs are compared cycle by cycle.
module tb_multicycle_decoder;

    typedef struct packed {
        logic       pc_s, next_pc, reg_w, mem_w, ir_write, adr_src, alu_src_a;
        logic [1:0] result_src, alu_src_b, imm_src, reg_src, flag_w;
        logic [2:0] alu_control;
        logic       instr_done, illegal;
    } outs_t;

    typedef struct {
        int         k;
        logic [1:0] op;
        logic [5:0] f;
        logic [3:0] rd;
        int         fst, mst;
        logic [2:0] aluc;
        logic [1:0] flag;
        bit         regw, memw, pcs;
        int         done;
        bit         ill;
    } vec_t;

    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4;
    localparam int P_MEMWR = 5, P_EXEC_R = 6, P_EXEC_I = 7, P_ALUWB = 8, P_BRANCH = 9;
    string pname [10] = '{"FETCH", "DECODE", "MEMADR", "MEMRD", "MEMWB",
                          "MEMWR", "EXEC_R", "EXEC_I", "ALUWB", "BRANCH"};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] op_i    [2] = '{2'b00, 2'b00};
    logic [5:0] funct_i [2] = '{6'd0, 6'd0};
    logic [3:0] rd_i    [2] = '{4'd0, 4'd0};
    logic       mr_i    [2] = '{1'b0, 1'b0};

    logic       pc_s_o [2], next_pc_o [2], reg_w_o [2], mem_w_o [2], ir_write_o [2];
    logic       adr_src_o [2], alu_src_a_o [2], instr_done_o [2], illegal_o [2];
    logic [1:0] result_src_o [2], alu_src_b_o [2], imm_src_o [2], reg_src_o [2], flag_w_o [2];
    logic [1:0] aluc2;
    logic [2:0] aluc3;

    int n_tests = 0;
    int n_fail  = 0;
    outs_t acc;
    int    done_cnt;

    always #5 clk = ~clk;

    multicycle_decoder #(.ALUC_W(2), .PC_IDX(15)) dut2 (
        .clk(clk), .rst(rst), .op(op_i[0]), .funct(funct_i[0]), .rd(rd_i[0]),
        .mem_ready(mr_i[0]), .pc_s(pc_s_o[0]), .next_pc(next_pc_o[0]), .reg_w(reg_w_o[0]),
        .mem_w(mem_w_o[0]), .ir_write(ir_write_o[0]), .adr_src(adr_src_o[0]),
        .alu_src_a(alu_src_a_o[0]), .result_src(result_src_o[0]), .alu_src_b(alu_src_b_o[0]),
        .imm_src(imm_src_o[0]), .reg_src(reg_src_o[0]), .flag_w(flag_w_o[0]),
        .alu_control(aluc2), .instr_done(instr_done_o[0]), .illegal(illegal_o[0]));

    multicycle_decoder #(.ALUC_W(3), .PC_IDX(15)) dut3 (
        .clk(clk), .rst(rst), .op(op_i[1]), .funct(funct_i[1]), .rd(rd_i[1]),
        .mem_ready(mr_i[1]), .pc_s(pc_s_o[1]), .next_pc(next_pc_o[1]), .reg_w(reg_w_o[1]),
        .mem_w(mem_w_o[1]), .ir_write(ir_write_o[1]), .adr_src(adr_src_o[1]),
        .alu_src_a(alu_src_a_o[1]), .result_src(result_src_o[1]), .alu_src_b(alu_src_b_o[1]),
        .imm_src(imm_src_o[1]), .reg_src(reg_src_o[1]), .flag_w(flag_w_o[1]),
        .alu_control(aluc3), .instr_done(instr_done_o[1]), .illegal(illegal_o[1]));

    function automatic outs_t get_out(input int k);
        outs_t o;
        o.pc_s = pc_s_o[k]; o.next_pc = next_pc_o[k]; o.reg_w = reg_w_o[k];
        o.mem_w = mem_w_o[k]; o.ir_write = ir_write_o[k]; o.adr_src = adr_src_o[k];
        o.alu_src_a = alu_src_a_o[k]; o.result_src = result_src_o[k];
        o.alu_src_b = alu_src_b_o[k]; o.imm_src = imm_src_o[k]; o.reg_src = reg_src_o[k];
        o.flag_w = flag_w_o[k]; o.alu_control = (k == 0) ? {1'b0, aluc2} : aluc3;
        o.instr_done = instr_done_o[k]; o.illegal = illegal_o[k];
        return o;
    endfunction

    // Command table: supported?, ALU code, arithmetic flags?, compare-only?
    function automatic void cmd_info(input int w, input logic [3:0] cmd, output bit ok,
                                     output logic [2:0] code, output bit ar, output bit ct);
        ok = 0; code = 3'd0; ar = 0; ct = 0;
        case (cmd)
            4'b0100: begin ok = 1; code = 3'd0; ar = 1; end
            4'b0010: begin ok = 1; code = 3'd1; ar = 1; end
            4'b0000: begin ok = 1; code = 3'd2; end
            4'b1100: begin ok = 1; code = 3'd3; end
            4'b0001: begin ok = (w == 3); code = 3'd4; end
            4'b1101: begin ok = (w == 3); code = 3'd5; end
            4'b1010: begin ok = (w == 3); code = 3'd1; ar = 1; ct = 1; end
            4'b1000: begin ok = (w == 3); code = 3'd2; ct = 1; end
            default: ;
        endcase
    endfunction

    function automatic outs_t exp_out(input int w, input int p, input bit mr, input logic [1:0] op,
                                      input logic [5:0] f, input logic [3:0] rd, input bit ill);
        outs_t e; bit ok, ar, ct; logic [2:0] code;
        e = '0;
        e.imm_src = op;
        e.reg_src = {op == 2'b01, op == 2'b10};
        e.illegal = ill;
        cmd_info(w, f[4:1], ok, code, ar, ct);
        case (p)
            P_FETCH:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.result_src = 2'b10;
                            e.ir_write = mr; e.next_pc = mr; end
            P_DECODE: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.result_src = 2'b10; end
            P_MEMADR: e.alu_src_b = 2'b01;
            P_MEMRD:  e.adr_src = 1;
            P_MEMWB:  begin e.result_src = 2'b01; e.reg_w = 1; e.pc_s = (rd == 4'd15);
                            e.instr_done = 1; end
            P_MEMWR:  begin e.adr_src = 1; e.mem_w = mr; e.instr_done = mr; end
            P_EXEC_R, P_EXEC_I: begin
                e.alu_src_b   = (p == P_EXEC_I) ? 2'b01 : 2'b00;
                e.alu_control = code;
                e.flag_w      = (f[0] || ct) ? (ar ? 2'b11 : 2'b10) : 2'b00;
                e.instr_done  = ct;
            end
            P_ALUWB:  begin e.reg_w = 1; e.pc_s = (rd == 4'd15); e.instr_done = 1; end
            P_BRANCH: begin e.alu_src_b = 2'b01; e.result_src = 2'b10; e.pc_s = 1;
                            e.instr_done = 1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input outs_t act, input outs_t ex);
        n_tests++;
        if (act !== ex) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", name, act, ex);
        end
    endtask

    // One clock of instruction k in phase p; the idle instance is held in FETCH
    task automatic cycle(input int k, input int p, input bit mr, input logic [1:0] op,
                         input logic [5:0] f, input logic [3:0] rd, input bit ill, input string tag);
        outs_t act;
        @(negedge clk);
        op_i[k] = op; funct_i[k] = f; rd_i[k] = rd; mr_i[k] = mr;
        mr_i[1-k] = 1'b0;
        #1;
        act = get_out(k);
        chk($sformatf("%s/%s/mr%0d", tag, pname[p], mr), act,
            exp_out((k == 0) ? 2 : 3, p, mr, op, f, rd, ill));
        acc = acc | act;
        if (act.instr_done) done_cnt++;
    endtask

    // Derive the state walk from the instruction class, then apply it
    task automatic run_instr(input int k, input logic [1:0] op, input logic [5:0] f,
                             input logic [3:0] rd, input int fst, input int mst, input string tag);
        int ph[$]; bit ok, ar, ct, bad, ill; logic [2:0] code; int st;
        cmd_info((k == 0) ? 2 : 3, f[4:1], ok, code, ar, ct);
        bad = (op == 2'b11) || (op == 2'b00 && !ok);
        ph.push_back(P_FETCH);
        ph.push_back(P_DECODE);
        if (!bad) begin
            case (op)
                2'b00: begin ph.push_back(f[5] ? P_EXEC_I : P_EXEC_R);
                             if (!ct) ph.push_back(P_ALUWB); end
                2'b01: begin ph.push_back(P_MEMADR);
                             if (f[0]) begin ph.push_back(P_MEMRD); ph.push_back(P_MEMWB); end
                             else ph.push_back(P_MEMWR); end
                default: ph.push_back(P_BRANCH);
            endcase
        end
        acc = '0; done_cnt = 0; ill = 0;
        foreach (ph[i]) begin
            if (ph[i] == P_FETCH || ph[i] == P_MEMRD || ph[i] == P_MEMWR) begin
                st = (ph[i] == P_FETCH) ? fst : mst;
                for (int c = 0; c <= st; c++) cycle(k, ph[i], c == st, op, f, rd, ill, tag);
            end else begin
                cycle(k, ph[i], 1'($urandom_range(0, 1)), op, f, rd, ill, tag);
            end
            ill = (ph[i] == P_DECODE) && bad;
        end
        if (bad) cycle(k, P_FETCH, 1'b0, op, f, rd, 1'b1, tag);
    endtask

    vec_t vt [17];

    initial begin
        logic [10:0] got, want;
        vt[0]  = '{1, 2'b00, 6'b001000, 4'd1,  0, 0, 3'd0, 2'b00, 1, 0, 0, 1, 0}; // ADD
        vt[1]  = '{0, 2'b00, 6'b001001, 4'd2,  0, 0, 3'd0, 2'b11, 1, 0, 0, 1, 0}; // ADDS
        vt[2]  = '{0, 2'b00, 6'b100101, 4'd3,  1, 0, 3'd1, 2'b11, 1, 0, 0, 1, 0}; // SUBS imm
        vt[3]  = '{0, 2'b00, 6'b000001, 4'd15, 0, 0, 3'd2, 2'b10, 1, 0, 1, 1, 0}; // ANDS pc
        vt[4]  = '{0, 2'b00, 6'b011000, 4'd4,  0, 0, 3'd3, 2'b00, 1, 0, 0, 1, 0}; // ORR
        vt[5]  = '{1, 2'b00, 6'b000011, 4'd5,  0, 0, 3'd4, 2'b10, 1, 0, 0, 1, 0}; // EORS
        vt[6]  = '{1, 2'b00, 6'b111010, 4'd6,  0, 0, 3'd5, 2'b00, 1, 0, 0, 1, 0}; // MOV imm
        vt[7]  = '{1, 2'b00, 6'b010101, 4'd15, 0, 0, 3'd1, 2'b11, 0, 0, 0, 1, 0}; // CMP
        vt[8]  = '{1, 2'b00, 6'b010000, 4'd0,  0, 0, 3'd2, 2'b10, 0, 0, 0, 1, 0}; // TST S=0
        vt[9]  = '{0, 2'b00, 6'b010101, 4'd0,  0, 0, 3'd0, 2'b00, 0, 0, 0, 0, 1}; // CMP narrow
        vt[10] = '{0, 2'b00, 6'b000011, 4'd0,  0, 0, 3'd0, 2'b00, 0, 0, 0, 0, 1}; // EOR narrow
        vt[11] = '{1, 2'b00, 6'b001110, 4'd0,  0, 0, 3'd0, 2'b00, 0, 0, 0, 0, 1}; // bad cmd
        vt[12] = '{0, 2'b11, 6'b000000, 4'd0,  0, 0, 3'd0, 2'b00, 0, 0, 0, 0, 1}; // op=11
        vt[13] = '{1, 2'b01, 6'b000001, 4'd15, 0, 3, 3'd0, 2'b00, 1, 0, 1, 1, 0}; // LDR pc
        vt[14] = '{0, 2'b01, 6'b000000, 4'd2,  2, 2, 3'd0, 2'b00, 0, 1, 0, 1, 0}; // STR
        vt[15] = '{1, 2'b10, 6'b101010, 4'd7,  0, 0, 3'd0, 2'b00, 0, 0, 1, 1, 0}; // B
        vt[16] = '{0, 2'b01, 6'b000001, 4'd3,  1, 1, 3'd0, 2'b00, 1, 0, 0, 1, 0}; // LDR

        // Reset: FETCH outputs, ir_write follows mem_ready even while held
        #1;
        for (int k = 0; k < 2; k++) chk($sformatf("reset%0d", k), get_out(k),
                                        exp_out(k == 0 ? 2 : 3, P_FETCH, 1'b0, 2'b00, 6'd0, 4'd0, 1'b0));
        mr_i[0] = 1'b1; #1;
        chk("reset_mr", get_out(0), exp_out(2, P_FETCH, 1'b1, 2'b00, 6'd0, 4'd0, 1'b0));
        mr_i[0] = 1'b0;
        @(negedge clk); @(negedge clk); rst = 1'b0;

        foreach (vt[i]) begin
            run_instr(vt[i].k, vt[i].op, vt[i].f, vt[i].rd, vt[i].fst, vt[i].mst, $sformatf("vec%0d", i));
            got  = {acc.alu_control, acc.flag_w, acc.reg_w, acc.mem_w, acc.pc_s, 2'(done_cnt), acc.illegal};
            want = {vt[i].aluc, vt[i].flag, vt[i].regw, vt[i].memw, vt[i].pcs, 2'(vt[i].done), vt[i].ill};
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL vec%0d_summary: got %b want %b", i, got, want);
            end
        end

        // Async reset while a store waits in MEMWR
        cycle(1, P_FETCH, 1'b1, 2'b01, 6'b000000, 4'd1, 1'b0, "rstwr");
        cycle(1, P_DECODE, 1'b0, 2'b01, 6'b000000, 4'd1, 1'b0, "rstwr");
        cycle(1, P_MEMADR, 1'b0, 2'b01, 6'b000000, 4'd1, 1'b0, "rstwr");
        cycle(1, P_MEMWR, 1'b0, 2'b01, 6'b000000, 4'd1, 1'b0, "rstwr");
        #2 rst = 1'b1; #1;
        chk("rstwr_async", get_out(1), exp_out(3, P_FETCH, 1'b0, 2'b01, 6'b000000, 4'd1, 1'b0));
        mr_i[1] = 1'b1; #1;
        chk("rstwr_mr", get_out(1), exp_out(3, P_FETCH, 1'b1, 2'b01, 6'b000000, 4'd1, 1'b0));
        @(negedge clk); mr_i[1] = 1'b0; rst = 1'b0;

        // Async reset clears a pending illegal pulse
        cycle(0, P_FETCH, 1'b1, 2'b11, 6'd0, 4'd0, 1'b0, "rstill");
        cycle(0, P_DECODE, 1'b0, 2'b11, 6'd0, 4'd0, 1'b0, "rstill");
        cycle(0, P_FETCH, 1'b0, 2'b11, 6'd0, 4'd0, 1'b1, "rstill");
        #2 rst = 1'b1; #1;
        chk("rstill_async", get_out(0), exp_out(2, P_FETCH, 1'b0, 2'b11, 6'd0, 4'd0, 1'b0));
        @(negedge clk); rst = 1'b0;

        // Random instruction stream on both widths
        for (int n = 0; n < 150; n++) begin
            logic [1:0] rop; logic [5:0] rf; logic [3:0] rrd;
            rop = 2'($urandom_range(0, 3));
            rf  = 6'($urandom_range(0, 63));
            rrd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            run_instr(int'($urandom_range(0, 1)), rop, rf, rrd,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
